product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream consumer of sequential_multiplier's 64-bit signed Product.
- Accumulates a programmed-length burst of signed products into a 64-bit running sum, using a valid/ready input handshake.
- Presents the final sum on an output handshake with a sticky overflow flag.
- Forms the accumulate half of the ALU's multiply-accumulate (dot-product) path.

Parameters:
- PROD_WIDTH, 64, width of incoming signed product (two's complement)
- ACC_WIDTH, 64, width of accumulator and result; must be >= PROD_WIDTH
- CNT_WIDTH, 8, width of burst length and beat counter

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- start  input  1  one-cycle pulse; begins a job; honoured only in IDLE
- len  input  CNT_WIDTH  number of products in the job; sampled when start is accepted
- product  input  PROD_WIDTH  signed product from sequential_multiplier
- prod_valid  input  1  product is valid this cycle
- prod_ready  output  1  accumulator accepts product this cycle
- acc_out  output  ACC_WIDTH  signed accumulated result
- acc_valid  output  1  acc_out is final
- acc_ready  input  1  consumer takes acc_out
- overflow  output  1  sticky signed-overflow flag for the current or last job
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE
  - acc_out=0, acc_valid=0, prod_ready=0, overflow=0, busy=0
  - internal count=0, len_q=0
- Reset mid-operation: the job is abandoned and all registers return to reset values on the next edge. rst dominates start.
- FSM IDLE:
  - On start: len_q<=len, count<=0, acc<=0, overflow<=0.
  - If len==0, go to DONE (acc_out=0). Otherwise go to ACCUM.
  - Asserting start in any other state has no effect.
- FSM ACCUM:
  - prod_ready=1 (registered, asserted the cycle after entry).
  - A beat is prod_valid&&prod_ready. On a beat:
    - acc <= acc + sign_extend(product) in ACC_WIDTH.
    - count <= count+1.
    - overflow |= signed overflow, defined as both operands having the same sign and the sum sign differing.
  - No beat means acc and count hold; prod_valid may idle any number of cycles.
  - The beat with count==len_q-1 moves to DONE. prod_ready deasserts in that same edge, so a product presented the following cycle is not consumed.
- FSM DONE:
  - acc_valid=1 from the cycle after the last beat (latency 1 cycle from last beat to result).
  - acc_out and overflow are held stable while acc_valid&&!acc_ready.
  - On acc_valid&&acc_ready, go to IDLE. acc_valid drops the next cycle.
  - acc_out and overflow keep their values in IDLE until the next start.
- Throughput: one product per cycle in ACCUM.
- Job cycle count: 1 (start) + len beats + 1 + output handshake wait.
- len=2^CNT_WIDTH-1 (255) is legal. The counter never wraps within a job.

Optional Feature:
- Macro: PRODUCT_ACC_SAT_EN.
- Defined: on signed overflow, acc saturates to the max positive value (0x7FFF_FFFF_FFFF_FFFF) or min negative value (0x8000_0000_0000_0000) according to the operand sign. Saturation persists into later beats as normal arithmetic from the clamped value. overflow is still set sticky.
- Not defined: two's-complement wrap-around; overflow set identically.

Test Plan:
- Basic signed sum: start, len=3, products -1560, 8100, -9900 back-to-back -> acc_valid one cycle after 3rd beat, acc_out=-3360 (0xFFFF_FFFF_FFFF_F2E0), overflow=0.
- Gapped input plus ignored start: len=2, products 246642 then -801600 with 4 idle cycles between; a start pulse is issued mid-job -> acc_out=-554958, start ignored, exactly 2 beats consumed.
- Overflow:
  - len=2, products 0x7FFF_FFFF_FFFF_FFFF then 1.
  - Without macro -> acc_out=0x8000_0000_0000_0000, overflow=1.
  - With PRODUCT_ACC_SAT_EN -> acc_out=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Zero length and backpressure:
  - len=0 -> DONE with acc_out=0, prod_ready never asserted.
  - Separately, hold acc_ready=0 for 5 cycles after acc_valid -> acc_out/acc_valid stable; IDLE the cycle after acc_ready=1.
- Reset mid-job: len=4, 2 beats (98765, 98765), assert rst 1 cycle -> next cycle all outputs 0, state IDLE. A fresh job len=1, product 8100 -> acc_out=8100, overflow=0.

Source files
------------

// File: rtl/product_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : product_accumulator                                             |
// | Summary  : Sums a programmed-length burst of signed products into a signed |
// |            running total with a sticky overflow flag and valid/ready I/O.  |
// |            Define PRODUCT_ACC_SAT_EN to clamp on overflow instead of wrap. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module product_accumulator #(
  parameter int PROD_WIDTH = 64,
  parameter int ACC_WIDTH  = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic [PROD_WIDTH-1:0] product,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  output logic [ACC_WIDTH-1:0]  acc_out,
  output logic                  acc_valid,
  input  logic                  acc_ready,
  output logic                  overflow,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [ACC_WIDTH-1:0] C_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] C_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_len_q;

  logic [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] w_acc_nxt;
  logic                 w_beat;
  logic                 w_last_beat;
  logic                 w_beat_ovf;

  assign w_prod_ext  = ACC_WIDTH'($signed(product));
  assign w_beat      = prod_valid && prod_ready;
  assign w_last_beat = w_beat && (r_count == (r_len_q - CNT_WIDTH'(1)));
  assign w_sum       = r_acc + w_prod_ext;

  // Signed overflow: operands agree in sign but the sum does not.
  assign w_beat_ovf = (r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

`ifdef PRODUCT_ACC_SAT_EN
  assign w_acc_nxt = w_beat_ovf ? (r_acc[ACC_WIDTH-1] ? C_ACC_MIN : C_ACC_MAX) : w_sum;
`else
  assign w_acc_nxt = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (len == '0) ? S_DONE : S_ACCUM;
      S_ACCUM: if (w_last_beat) w_state_nxt = S_DONE;
      S_DONE:  if (acc_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so prod_ready is glitch-free.
  always_comb begin
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    busy       = 1'b0;
    case (r_state)
      S_ACCUM: begin
        prod_ready = 1'b1;
        busy       = 1'b1;
      end
      S_DONE: begin
        acc_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
      r_len_q <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len_q <= len;
            r_count <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (w_beat) begin
            r_acc   <= w_acc_nxt;
            r_count <= r_count + CNT_WIDTH'(1);
            r_ovf   <= r_ovf | w_beat_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign acc_out  = r_acc;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// Testbench for product_accumulator: directed scenarios plus randomized jobs
// checked against an exact-arithmetic reference model.
module tb_product_accumulator;

  localparam longint LMAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam longint LMIN = -LMAX - 64'sd1;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [63:0] product;
  logic        prod_valid;
  logic        prod_ready;
  logic [63:0] acc_out;
  logic        acc_valid;
  logic        acc_ready;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [63:0] job_q[$];

  always #5 clk = ~clk;

  product_accumulator #(.PROD_WIDTH(64), .ACC_WIDTH(64), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .product(product),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .overflow(overflow), .busy(busy)
  );

  // Reference: exact 66-bit sum per beat, then wrap or clamp into 64 bits.
  task automatic model_job(input int n, output logic [63:0] exp_acc, output logic exp_ovf);
    logic signed [65:0] s;
    longint a;
    a = 0;
    exp_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = 66'(a) + 66'($signed(job_q[i]));
      if (s > 66'(LMAX) || s < 66'(LMIN)) begin
        exp_ovf = 1'b1;
`ifdef PRODUCT_ACC_SAT_EN
        a = (s > 0) ? LMAX : LMIN;
`else
        a = longint'(s[63:0]);
`endif
      end else begin
        a = longint'(s[63:0]);
      end
    end
    exp_acc = a;
  endtask

  function automatic logic [63:0] rand_prod();
    logic [63:0] p;
    int m;
    p = {$urandom, $urandom};
    m = $urandom_range(0, 2);
    if (m == 0) p = {{32{p[31]}}, p[31:0]};
    else if (m == 2) p = p[16] ? (LMAX - {48'd0, p[15:0]}) : (LMIN + {48'd0, p[15:0]});
    return p;
  endfunction

  // Drives one job from job_q; reports what was observed for the caller to check.
  task automatic run_job(input int n, input int gap_pct, input int fixed_gap, input int hold,
                         input int start_at, output logic [63:0] res, output logic ovf,
                         output int beats, output int lat, output bit saw_ready,
                         output bit stable, output bit released, output bit timeout);
    int idx, cyc, last_cyc, budget, idle_left;
    idx = 0; cyc = 0; last_cyc = 0; idle_left = 0; beats = 0;
    saw_ready = 0; stable = 1; released = 0; timeout = 0;
    budget = n * 4 * (gap_pct + fixed_gap + 2) + 20;
    @(negedge clk);
    start = 1'b1; len = 8'(n); acc_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!acc_valid && cyc < budget) begin
      if (prod_ready) saw_ready = 1;
      start = (cyc == start_at);
      len   = 8'd1;
      if (idle_left > 0) begin
        prod_valid = 1'b0;
        idle_left--;
      end else if (idx < n) begin
        prod_valid = ($urandom_range(0, 99) >= gap_pct);
        product    = job_q[idx];
      end else begin
        prod_valid = 1'b1;
        product    = JUNK;
      end
      if (prod_valid && prod_ready) begin
        if (idx < n) idx++;
        beats++;
        last_cyc  = cyc;
        idle_left = fixed_gap;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    timeout = !acc_valid;
    lat = cyc - last_cyc;
    res = acc_out;
    ovf = overflow;
    if (timeout) begin
      prod_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      prod_valid = 1'b1;
      product    = JUNK;
      for (int h = 0; h < hold; h++) begin
        if (prod_ready) beats++;
        @(negedge clk);
        if (acc_out !== res || overflow !== ovf || acc_valid !== 1'b1) stable = 0;
      end
      if (prod_ready) beats++;
      acc_ready = 1'b1;
      @(negedge clk);
      released = (acc_valid === 1'b0) && (busy === 1'b0) && (acc_out === res);
      acc_ready  = 1'b0;
      prod_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; len = 8'd3; product = '0; prod_valid = 1'b0; acc_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (acc_out !== 64'd0) begin failures++; $display("FAIL reset_acc_out got=%h exp=0", acc_out); end
    checks++; if (acc_valid !== 1'b0) begin failures++; $display("FAIL reset_acc_valid got=%b exp=0", acc_valid); end
    checks++; if (prod_ready !== 1'b0) begin failures++; $display("FAIL reset_prod_ready got=%b exp=0", prod_ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [63:0] res; logic ovf; int beats, lat; bit sr, st, rel, to;
    job_q = '{-64'sd1560, 64'sd8100, -64'sd9900};
    run_job(3, 0, 0, 0, -1, res, ovf, beats, lat, sr, st, rel, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=timeout exp=acc_valid"); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_F2E0) begin failures++; $display("FAIL basic_acc got=%h exp=fffffffffffff2e0", res); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", ovf); end
    checks++; if (beats != 3) begin failures++; $display("FAIL basic_beats got=%0d exp=3", beats); end
    checks++; if (lat != 1) begin failures++; $display("FAIL basic_latency got=%0d exp=1", lat); end
    checks++; if (!rel) begin failures++; $display("FAIL basic_release got=%b exp=1", rel); end
  endtask

  task automatic test_gapped_ignored_start();
    logic [63:0] res; logic ovf; int beats, lat; bit sr, st, rel, to;
    job_q = '{64'sd246642, -64'sd801600};
    run_job(2, 0, 4, 0, 2, res, ovf, beats, lat, sr, st, rel, to);
    checks++; if (res !== 64'(-64'sd554958)) begin failures++; $display("FAIL gapped_acc got=%h exp=%h", res, 64'(-64'sd554958)); end
    checks++; if (beats != 2) begin failures++; $display("FAIL gapped_beats got=%0d exp=2", beats); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL gapped_ovf got=%b exp=0", ovf); end
    checks++; if (lat != 1 || to) begin failures++; $display("FAIL gapped_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_overflow();
    logic [63:0] res, exp_res; logic ovf; int beats, lat; bit sr, st, rel, to;
`ifdef PRODUCT_ACC_SAT_EN
    exp_res = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    exp_res = 64'h8000_0000_0000_0000;
`endif
    job_q = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
    run_job(2, 0, 0, 0, -1, res, ovf, beats, lat, sr, st, rel, to);
    checks++; if (res !== exp_res) begin failures++; $display("FAIL ovf_acc got=%h exp=%h", res, exp_res); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
  endtask

  task automatic test_zero_len_backpressure();
    logic [63:0] res, exp_res; logic ovf, exp_ovf; int beats, lat; bit sr, st, rel, to;
    job_q.delete();
    run_job(0, 0, 0, 0, -1, res, ovf, beats, lat, sr, st, rel, to);
    checks++; if (res !== 64'd0 || to) begin failures++; $display("FAIL zero_acc got=%h exp=0", res); end
    checks++; if (sr || beats != 0) begin failures++; $display("FAIL zero_ready got=%0d beats exp=0 and no ready", beats); end
    checks++; if (lat != 0) begin failures++; $display("FAIL zero_latency got=%0d exp=0", lat); end
    job_q = '{rand_prod(), rand_prod()};
    model_job(2, exp_res, exp_ovf);
    run_job(2, 20, 0, 5, -1, res, ovf, beats, lat, sr, st, rel, to);
    checks++; if (res !== exp_res || ovf !== exp_ovf) begin failures++; $display("FAIL bp_result got=%h/%b exp=%h/%b", res, ovf, exp_res, exp_ovf); end
    checks++; if (!st) begin failures++; $display("FAIL bp_stable got=%b exp=1", st); end
    checks++; if (!rel) begin failures++; $display("FAIL bp_release got=%b exp=1", rel); end
  endtask

  task automatic test_reset_mid_job();
    logic [63:0] res; logic ovf; int beats, lat; bit sr, st, rel, to;
    @(negedge clk);
    start = 1'b1; len = 8'd4;
    @(negedge clk);
    start = 1'b0; prod_valid = 1'b1; product = 64'd98765;
    repeat (2) @(negedge clk);
    prod_valid = 1'b0;
    checks++; if (acc_out !== 64'd197530) begin failures++; $display("FAIL mid_partial got=%h exp=%h", acc_out, 64'd197530); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({acc_out, acc_valid, prod_ready, overflow, busy} !== 68'd0) begin
      failures++; $display("FAIL mid_reset got=%h/%b%b%b%b exp=all zero", acc_out, acc_valid, prod_ready, overflow, busy);
    end
    job_q = '{64'sd8100};
    run_job(1, 0, 0, 0, -1, res, ovf, beats, lat, sr, st, rel, to);
    checks++; if (res !== 64'd8100 || ovf !== 1'b0) begin failures++; $display("FAIL mid_fresh got=%h/%b exp=%h/0", res, ovf, 64'd8100); end
    checks++; if (beats != 1 || lat != 1) begin failures++; $display("FAIL mid_fresh_beats got=%0d/%0d exp=1/1", beats, lat); end
  endtask

  task automatic test_random();
    logic [63:0] res, exp_res; logic ovf, exp_ovf; int n, beats, lat; bit sr, st, rel, to;
    for (int j = 0; j < 24; j++) begin
      n = (j == 0) ? 255 : $urandom_range(1, 12);
      job_q.delete();
      for (int k = 0; k < n; k++) job_q.push_back(rand_prod());
      model_job(n, exp_res, exp_ovf);
      run_job(n, $urandom_range(0, 50), 0, $urandom_range(0, 3), -1, res, ovf, beats, lat, sr, st, rel, to);
      checks++; if (res !== exp_res || ovf !== exp_ovf) begin
        failures++; $display("FAIL rand_result job=%0d len=%0d got=%h/%b exp=%h/%b", j, n, res, ovf, exp_res, exp_ovf);
      end
      checks++; if (beats != n || lat != 1 || !rel || !st || to) begin
        failures++; $display("FAIL rand_handshake job=%0d got beats=%0d lat=%0d rel=%b st=%b exp beats=%0d lat=1", j, beats, lat, rel, st, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped_ignored_start();
    test_overflow();
    test_zero_len_backpressure();
    test_reset_mid_job();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
